// File: rtl/alu_wb_stage_pkg.sv
// ============================================================================
// Module : alu_wb_stage_pkg
// Brief  : Shared ALU control codes, branch condition codes and flag layout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_wb_stage_pkg;

  localparam int c_xlen = 32;

  // Flag vector layout is {V,C,N,Z}
  localparam int c_flag_v = 3;
  localparam int c_flag_c = 2;
  localparam int c_flag_n = 1;
  localparam int c_flag_z = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct3_e;

  // x0 is hardwired to zero, and branches never write a register
  function automatic logic wb_we(input logic reg_write, input logic is_branch,
                                 input logic [4:0] rd);
    return reg_write & ~is_branch & (rd != 5'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_wb_stage_if.sv
// ============================================================================
// Module : alu_wb_stage_if
// Brief  : Upstream (ALU) and downstream (writeback) handshake bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface alu_wb_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_result;
  logic [XLEN-1:0] in_slt;
  logic [3:0]      in_flags;
  logic [2:0]      in_alu_ctrl;
  logic [4:0]      in_rd;
  logic            in_reg_write;
  logic            in_is_branch;
  logic [2:0]      in_funct3;

  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_data;
  logic            out_we;
  logic            out_br_taken;
  logic            out_br_illegal;
  logic [3:0]      out_flags;

  modport master (
    output in_valid, in_result, in_slt, in_flags, in_alu_ctrl, in_rd,
           in_reg_write, in_is_branch, in_funct3, out_ready,
    input  in_ready, out_valid, out_rd, out_data, out_we, out_br_taken,
           out_br_illegal, out_flags
  );

  modport slave (
    input  in_valid, in_result, in_slt, in_flags, in_alu_ctrl, in_rd,
           in_reg_write, in_is_branch, in_funct3, out_ready,
    output in_ready, out_valid, out_rd, out_data, out_we, out_br_taken,
           out_br_illegal, out_flags
  );
endinterface

`default_nettype wire

// File: rtl/alu_br_resolve.sv
// ============================================================================
// Module : alu_br_resolve
// Brief  : Resolves a conditional branch from the {V,C,N,Z} flags of A-B.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_br_resolve
  import alu_wb_stage_pkg::*;
(
  input  wire logic       is_branch,
  input  wire logic [2:0] funct3,
  input  wire logic [3:0] flags,
  output logic            taken,
  output logic            illegal
);

  logic w_lt;
  assign w_lt = flags[c_flag_n] ^ flags[c_flag_v];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (is_branch) begin
      // C is the no-borrow flag of A-B, so unsigned less-than is !C
      case (funct3)
        BR_BEQ:  taken = flags[c_flag_z];
        BR_BNE:  taken = ~flags[c_flag_z];
        BR_BLT:  taken = w_lt;
        BR_BGE:  taken = ~w_lt;
        BR_BLTU: taken = ~flags[c_flag_c];
        BR_BGEU: taken = flags[c_flag_c];
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_wb_stage.sv
// ============================================================================
// Module : alu_wb_stage
// Brief  : Execute-to-writeback stage: 2-entry skid buffer, writeback select,
//          branch resolution and retired-op counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int XLEN  = c_xlen,
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             flush,
  alu_wb_stage_if.slave         bus,
  output logic [CNT_W-1:0]      retired_cnt
);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            we;
    logic            br_taken;
    logic            br_illegal;
    logic [3:0]      flags;
  } entry_t;

  entry_t           r_main;
  entry_t           r_skid;
  logic             r_main_valid;
  logic             r_skid_valid;
  logic [CNT_W-1:0] r_cnt;

  entry_t w_new;
  logic   w_taken;
  logic   w_illegal;
  logic   w_accept;
  logic   w_drain;

  alu_br_resolve u_br_resolve (
    .is_branch (bus.in_is_branch),
    .funct3    (bus.in_funct3),
    .flags     (bus.in_flags),
    .taken     (w_taken),
    .illegal   (w_illegal)
  );

  always_comb begin
    w_new            = '0;
    w_new.rd         = bus.in_rd;
    w_new.data       = (bus.in_alu_ctrl == ALU_SLT) ? bus.in_slt : bus.in_result;
    w_new.we         = wb_we(bus.in_reg_write, bus.in_is_branch, bus.in_rd);
    w_new.br_taken   = w_taken;
    w_new.br_illegal = w_illegal;
    w_new.flags      = bus.in_flags;
  end

  // in_ready depends only on registered skid state, never on out_ready
  assign bus.in_ready = ~r_skid_valid;
  assign w_accept     = bus.in_valid & ~r_skid_valid & ~flush;
  assign w_drain      = r_main_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (w_drain) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (flush) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_drain) begin
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_main <= w_new;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_main_valid) begin
          r_main       <= w_new;
          r_main_valid <= 1'b1;
        end else begin
          r_skid       <= w_new;
          r_skid_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.out_valid      = r_main_valid;
  assign bus.out_rd         = r_main.rd;
  assign bus.out_data       = r_main.data;
  assign bus.out_we         = r_main.we;
  assign bus.out_br_taken   = r_main.br_taken;
  assign bus.out_br_illegal = r_main.br_illegal;
  assign bus.out_flags      = r_main.flags;
  assign retired_cnt        = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
// ============================================================================
// Module : tb_alu_wb_stage
// Brief  : Directed scoreboard bench for alu_wb_stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_wb_stage;
  import alu_wb_stage_pkg::*;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        taken;
    logic        illegal;
    logic [3:0]  flags;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] retired_cnt;

  alu_wb_stage_if #(.XLEN(32)) bus ();

  alu_wb_stage #(.XLEN(32), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus.slave),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  exp_t       cur_exp;
  int         n_cmp   = 0;
  int         n_err   = 0;
  logic [3:0] cnt_exp = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one op; expectations come from A/B directly, not from the flags
  task automatic set_op(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rw, input logic br,
                        input logic [2:0] f3);
    logic [31:0] res, slt, diff;
    logic [3:0]  fl;
    logic        lt_s, lt_u, eq, tk, il;
    diff = a - b;
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    eq   = (a == b);
    case (ctrl)
      3'b000:  res = a + b;
      3'b001:  res = diff;
      3'b010:  res = a & b;
      3'b011:  res = a | b;
      default: res = 32'hDEAD_BEEF;
    endcase
    slt = {31'd0, lt_s};
    fl  = {(a[31] != b[31]) && (diff[31] != a[31]), !lt_u, diff[31], eq};
    tk  = 1'b0;
    il  = 1'b0;
    if (br) begin
      case (f3)
        3'b000:  tk = eq;
        3'b001:  tk = !eq;
        3'b100:  tk = lt_s;
        3'b101:  tk = !lt_s;
        3'b110:  tk = lt_u;
        3'b111:  tk = !lt_u;
        default: il = 1'b1;
      endcase
    end
    bus.in_valid     = 1'b1;
    bus.in_result    = res;
    bus.in_slt       = slt;
    bus.in_flags     = fl;
    bus.in_alu_ctrl  = ctrl;
    bus.in_rd        = rd;
    bus.in_reg_write = rw;
    bus.in_is_branch = br;
    bus.in_funct3    = f3;
    cur_exp = '{rd, (ctrl == 3'b101) ? slt : res, rw && !br && (rd != 5'd0), tk, il, fl};
  endtask

  task automatic tick();
    logic acc, drn;
    exp_t e;
    acc = bus.in_valid && bus.in_ready && !flush;
    drn = bus.out_valid && bus.out_ready;
    if (drn) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("entry", {20'd0, bus.out_rd, bus.out_data, bus.out_we, bus.out_br_taken,
                        bus.out_br_illegal, bus.out_flags}, {20'd0, e});
      end
      cnt_exp = cnt_exp + 4'd1;
    end
    if (flush) sb.delete();
    else if (acc) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw, input logic br,
                         input logic [2:0] f3);
    logic acc;
    logic done;
    done = 1'b0;
    set_op(ctrl, a, b, rd, rw, br, f3);
    for (int i = 0; i < 20; i++) begin
      acc = bus.in_ready;
      tick();
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    check("accept_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic drain_all();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_result    = '0;
    bus.in_slt       = '0;
    bus.in_flags     = '0;
    bus.in_alu_ctrl  = '0;
    bus.in_rd        = '0;
    bus.in_reg_write = 1'b0;
    bus.in_is_branch = 1'b0;
    bus.in_funct3    = '0;
    bus.out_ready    = 1'b1;

    #2;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_cnt", {60'd0, retired_cnt}, 64'd0);
    check("rst_out_data", {32'd0, bus.out_data}, 64'd0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_we", {63'd0, bus.out_we}, 64'd0);

    // ADD 10+5 to x3, one-cycle latency
    push_op(3'b000, 32'd10, 32'd5, 5'd3, 1'b1, 1'b0, 3'b000);
    bus.in_valid = 1'b0;
    check("add_latency_valid", {63'd0, bus.out_valid}, 64'd1);
    check("add_data", {32'd0, bus.out_data}, 64'd15);
    drain_all();
    check("cnt_after_add", {60'd0, retired_cnt}, {60'd0, cnt_exp});

    // SLT selects the slt input; rd=x0 suppresses write enable
    push_op(3'b101, 32'd3, 32'd7, 5'd4, 1'b1, 1'b0, 3'b000);
    push_op(3'b101, 32'd3, 32'd7, 5'd0, 1'b1, 1'b0, 3'b000);
    drain_all();

    // Branch resolution via SUB, including signed overflow and sign boundary
    push_op(3'b001, 32'd5, 32'd10, 5'd1, 1'b1, 1'b1, 3'b100);
    push_op(3'b001, 32'd5, 32'd10, 5'd1, 1'b1, 1'b1, 3'b110);
    push_op(3'b001, 32'd5, 32'd10, 5'd1, 1'b1, 1'b1, 3'b101);
    push_op(3'b001, 32'd15, 32'd15, 5'd2, 1'b0, 1'b1, 3'b000);
    push_op(3'b001, 32'd15, 32'd15, 5'd2, 1'b0, 1'b1, 3'b001);
    push_op(3'b001, 32'd15, 32'd15, 5'd2, 1'b0, 1'b1, 3'b010);
    push_op(3'b001, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b0, 1'b1, 3'b111);
    push_op(3'b001, 32'h8000_0000, 32'd1, 5'd2, 1'b0, 1'b1, 3'b100);
    drain_all();
    check("cnt_after_br", {60'd0, retired_cnt}, {60'd0, cnt_exp});

    // Backpressure: two held, third waits, order preserved on release
    bus.out_ready = 1'b0;
    set_op(3'b000, 32'd100, 32'd1, 5'd10, 1'b1, 1'b0, 3'b000);
    tick();
    set_op(3'b010, 32'hF0F0, 32'h0FF0, 5'd11, 1'b1, 1'b0, 3'b000);
    tick();
    check("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    set_op(3'b011, 32'hA000, 32'h000B, 5'd12, 1'b1, 1'b0, 3'b000);
    tick();
    tick();
    check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("hold_data", {32'd0, bus.out_data}, {32'd0, sb[0].data});
    check("hold_sb_depth", 64'(sb.size()), 64'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic acc;
      acc = bus.in_ready;
      tick();
      if (acc) break;
    end
    drain_all();
    check("cnt_after_bp", {60'd0, retired_cnt}, {60'd0, cnt_exp});

    // Flush with both entries full and a beat presented
    bus.out_ready = 1'b0;
    set_op(3'b000, 32'd1, 32'd2, 5'd5, 1'b1, 1'b0, 3'b000);
    tick();
    set_op(3'b000, 32'd3, 32'd4, 5'd6, 1'b1, 1'b0, 3'b000);
    tick();
    set_op(3'b000, 32'd5, 32'd6, 5'd7, 1'b1, 1'b0, 3'b000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("flush_cnt", {60'd0, retired_cnt}, {60'd0, cnt_exp});
    bus.out_ready = 1'b1;
    tick();
    check("flush_stays_empty", {63'd0, bus.out_valid}, 64'd0);

    // Async reset mid-stream, between clock edges
    bus.out_ready = 1'b0;
    set_op(3'b000, 32'd7, 32'd8, 5'd9, 1'b1, 1'b0, 3'b000);
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("arst_out_data", {32'd0, bus.out_data}, 64'd0);
    check("arst_out_we", {63'd0, bus.out_we}, 64'd0);
    check("arst_cnt", {60'd0, retired_cnt}, 64'd0);
    sb.delete();
    cnt_exp = '0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // 17 back-to-back hand-offs wrap a 4-bit counter to 1
    bus.out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      push_op(3'b000, 32'(k), 32'd1000, 5'(k + 1), 1'b1, 1'b0, 3'b000);
    end
    drain_all();
    check("wrap_cnt", {60'd0, retired_cnt}, {60'd0, cnt_exp});
    check("wrap_cnt_one", {60'd0, cnt_exp}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
